memory_stage_controller: RTL and testbench
==========================================

Name: memory_stage_controller

Overview:
- Sequences the memory stage of the 5-stage pipeline.
- Decodes each load/store leaving the execute-to-memory pipeline register into the data memory (DMEM) or the UART MMIO window, and drives the selected target.
- Holds the pipeline with `stall_pipeline` while a multi-cycle access is in flight, and returns load data to writeback.

Parameters:
- `UART_BASE`, 32'h8000_0000, base address of the UART register window.
- `UART_MASK`, 32'hFFFF_FFF0, address bits compared against `UART_BASE`; this gives a 16-byte window.
- `TIMEOUT_CYCLES`, 255, maximum number of cycles spent waiting for `uart_ready` before the access is aborted.
- `CNT_W`, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `mem_read`  in  1  memory-stage load request.
- `mem_write`  in  1  memory-stage store request.
- `alu_memory_write`  in  32  effective address from the pipeline register.
- `read_data_2_write`  in  32  store data from the pipeline register.
- `stall_pipeline`  out  1  hold all pipeline registers and the PC.
- `load_data`  out  32  registered load result.
- `load_valid`  out  1  `load_data` is valid this cycle.
- `bus_error`  out  1  one-cycle pulse: UART timeout.
- `misalign_error`  out  1  one-cycle pulse: `addr[1:0]` is not 0.
- `dmem_we`  out  1  DMEM write enable.
- `dmem_re`  out  1  DMEM read enable.
- `dmem_addr`  out  32  DMEM address.
- `dmem_wdata`  out  32  DMEM write data.
- `dmem_rdata`  in  32  DMEM read data, valid 1 cycle after `dmem_re`.
- `uart_req`  out  1  UART access request; held until `uart_ready`.
- `uart_we`  out  1  1 = write, 0 = read.
- `uart_addr`  out  4  byte offset within the UART window.
- `uart_wdata`  out  32  UART write data.
- `uart_rdata`  in  32  UART read data, valid when `uart_ready` = 1.
- `uart_ready`  in  1  UART accepts/completes the access this cycle.

Behaviour:
- Reset (`reset` = 0, asynchronous):
  - state goes to IDLE and the counter is cleared.
  - All outputs are 0, including `load_data`, `uart_req` and the latched `uart_addr`/`uart_wdata`.
- Request decode:
  - `req` = `mem_read` | `mem_write`.
  - Write has priority if both are asserted.
  - `is_uart` = ((`addr` & `UART_MASK`) == `UART_BASE`); otherwise the access targets DMEM.
- Misalignment: if `req` is set and `addr[1:0]` is not 0, there is no access and no stall; `misalign_error` pulses for 1 cycle in IDLE.
- States: IDLE, DMEM_RD, UART_WAIT, DONE.
- IDLE, DMEM store:
  - `dmem_we` = 1 combinationally, `stall_pipeline` = 0, remain in IDLE. Zero-cycle cost.
- IDLE, DMEM load:
  - `dmem_re` = 1 and `stall_pipeline` = 1; go to DMEM_RD.
- DMEM_RD:
  - `stall_pipeline` = 1; capture `dmem_rdata` into `load_data`; go to DONE.
- IDLE, UART access:
  - `stall_pipeline` = 1.
  - Latch `we`, `addr[3:0]` and `wdata` into the `uart_*` registers; clear the counter; go to UART_WAIT.
- UART_WAIT:
  - `uart_req` = 1 and `stall_pipeline` = 1; the counter increments each cycle.
  - If `uart_ready` = 1: capture `uart_rdata` if the access is a read, and go to DONE.
  - Otherwise, if counter == TIMEOUT_CYCLES-1: set `load_data` = 0, flag the error, and go to DONE.
  - `uart_ready` takes priority over timeout in the same cycle.
- DONE:
  - `stall_pipeline` = 0.
  - `load_valid` = 1 for loads only.
  - `bus_error` pulses if the access timed out.
  - `uart_req` = 0; go to IDLE unconditionally.
  - The still-present request is treated as consumed and is not reissued.
- Stall cycles by access type:
  - DMEM store: 0.
  - DMEM load: 2.
  - UART: N+1, where N = cycles until `uart_ready`.
- `load_data` holds its value until the next capture. `load_valid` is never asserted outside DONE.
- A `uart_ready` arriving while not in UART_WAIT is ignored.
- Reset during UART_WAIT aborts immediately: `uart_req` drops asynchronously and no error is raised.

Decomposition:
- Package `lsu_ctrl_pkg`:
  - typedef enum `mem_ctrl_state_t` {IDLE, DMEM_RD, UART_WAIT, DONE}.
  - Default `UART_BASE`, `UART_MASK` and `TIMEOUT_CYCLES` constants.
- Sub-module `lsu_addr_decode`: combinational; produces `is_uart`, `misaligned` and `uart_offset` from the address.

Test Plan:
1. DMEM store to 0x0000_0040, data 0xDEAD_BEEF -> `dmem_we` = 1 in the same cycle, `stall_pipeline` never asserted.
2. DMEM load from 0x0000_0040 with `dmem_rdata` = 0xDEAD_BEEF -> stall for 2 cycles; in the third cycle `load_valid` = 1 and `load_data` = 0xDEAD_BEEF.
3. UART write to 0x8000_0004, data 0x41, `uart_ready` after 3 cycles -> `uart_addr` = 4, `uart_we` = 1, `uart_req` high 3 cycles, stall 4 cycles, no `load_valid`.
4. UART read from 0x8000_0008, `uart_ready` never asserted, TIMEOUT_CYCLES = 255 -> after 255 wait cycles: DONE, `load_data` = 0, `bus_error` pulses once, stall released.
5. Load from 0x0000_0042 -> `misalign_error` pulses once; no `dmem_re`, no stall, no `load_valid`.
6. `reset` driven to 0 for 1 cycle, 2 cycles into UART_WAIT -> outputs 0 asynchronously, state IDLE, no `bus_error`; a fresh UART read afterwards completes normally.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// Shared types and default constants for the memory-stage load/store controller.
package lsu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DMEM_RD   = 2'd1,
    UART_WAIT = 2'd2,
    DONE      = 2'd3
  } mem_ctrl_state_t;

  localparam logic [31:0] DEFAULT_UART_BASE      = 32'h8000_0000;
  localparam logic [31:0] DEFAULT_UART_MASK      = 32'hFFFF_FFF0;
  localparam int          DEFAULT_TIMEOUT_CYCLES = 255;
  localparam int          DEFAULT_CNT_W          = 8;

endpackage

// File: rtl/lsu_addr_decode.sv
// Combinational address decode: UART window hit, word misalignment, UART byte offset.
module lsu_addr_decode #(
  parameter logic [31:0] UART_BASE = 32'h8000_0000,
  parameter logic [31:0] UART_MASK = 32'hFFFF_FFF0
) (
  input  logic [31:0] addr,
  output logic        is_uart,
  output logic        misaligned,
  output logic [3:0]  uart_offset
);

  assign is_uart     = ((addr & UART_MASK) == UART_BASE);
  assign misaligned  = |addr[1:0];
  assign uart_offset = addr[3:0];

endmodule

// File: rtl/memory_stage_controller.sv
// Memory-stage sequencer: routes loads/stores to DMEM or the UART window and
// stalls the pipeline while a multi-cycle access is outstanding.
module memory_stage_controller
  import lsu_ctrl_pkg::*;
#(
  parameter logic [31:0] UART_BASE      = DEFAULT_UART_BASE,
  parameter logic [31:0] UART_MASK      = DEFAULT_UART_MASK,
  parameter int          TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int          CNT_W          = DEFAULT_CNT_W
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] alu_memory_write,
  input  logic [31:0] read_data_2_write,
  output logic        stall_pipeline,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        bus_error,
  output logic        misalign_error,
  output logic        dmem_we,
  output logic        dmem_re,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  output logic        uart_req,
  output logic        uart_we,
  output logic [3:0]  uart_addr,
  output logic [31:0] uart_wdata,
  input  logic [31:0] uart_rdata,
  input  logic        uart_ready
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  mem_ctrl_state_t  state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             op_read;
  logic             timed_out;

  logic             req;
  logic             is_write;
  logic             is_uart;
  logic             misaligned;
  logic [3:0]       uart_offset;
  logic             accept_uart;
  logic             timeout_hit;

  lsu_addr_decode #(
    .UART_BASE (UART_BASE),
    .UART_MASK (UART_MASK)
  ) u_decode (
    .addr        (alu_memory_write),
    .is_uart     (is_uart),
    .misaligned  (misaligned),
    .uart_offset (uart_offset)
  );

  assign req         = mem_read | mem_write;
  assign is_write    = mem_write;
  assign timeout_hit = (cnt == TIMEOUT_LAST);

  // Combinational outputs are qualified by reset so every output reads 0
  // while reset is held, even with a request still present on the inputs.
  always_comb begin
    state_next     = state;
    stall_pipeline = 1'b0;
    dmem_we        = 1'b0;
    dmem_re        = 1'b0;
    dmem_addr      = 32'h0;
    dmem_wdata     = 32'h0;
    misalign_error = 1'b0;
    uart_req       = 1'b0;
    load_valid     = 1'b0;
    bus_error      = 1'b0;
    accept_uart    = 1'b0;
    if (reset) begin
      case (state)
        IDLE: begin
          if (req) begin
            if (misaligned) begin
              misalign_error = 1'b1;
            end else if (is_uart) begin
              stall_pipeline = 1'b1;
              accept_uart    = 1'b1;
              state_next     = UART_WAIT;
            end else if (is_write) begin
              dmem_we    = 1'b1;
              dmem_addr  = alu_memory_write;
              dmem_wdata = read_data_2_write;
            end else begin
              dmem_re        = 1'b1;
              dmem_addr      = alu_memory_write;
              stall_pipeline = 1'b1;
              state_next     = DMEM_RD;
            end
          end
        end
        DMEM_RD: begin
          stall_pipeline = 1'b1;
          state_next     = DONE;
        end
        UART_WAIT: begin
          uart_req       = 1'b1;
          stall_pipeline = 1'b1;
          if (uart_ready || timeout_hit) state_next = DONE;
        end
        DONE: begin
          // The request still on the inputs was consumed; the pipeline advances now.
          load_valid = op_read;
          bus_error  = timed_out;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      op_read    <= 1'b0;
      timed_out  <= 1'b0;
      load_data  <= 32'h0;
      uart_we    <= 1'b0;
      uart_addr  <= 4'h0;
      uart_wdata <= 32'h0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept_uart) begin
            uart_we    <= is_write;
            uart_addr  <= uart_offset;
            uart_wdata <= read_data_2_write;
            cnt        <= '0;
            timed_out  <= 1'b0;
            op_read    <= ~is_write;
          end else if (dmem_re) begin
            op_read   <= 1'b1;
            timed_out <= 1'b0;
          end
        end
        DMEM_RD: load_data <= dmem_rdata;
        UART_WAIT: begin
          cnt <= cnt + CNT_ONE;
          if (uart_ready) begin
            if (!uart_we) load_data <= uart_rdata;
          end else if (timeout_hit) begin
            load_data <= 32'h0;
            timed_out <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage_controller.sv
// Directed bench for memory_stage_controller with an event scoreboard.
module tb_memory_stage_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] alu_memory_write = 32'h0;
  logic [31:0] read_data_2_write = 32'h0;
  logic        stall_pipeline;
  logic [31:0] load_data;
  logic        load_valid;
  logic        bus_error;
  logic        misalign_error;
  logic        dmem_we;
  logic        dmem_re;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = 32'h0;
  logic        uart_req;
  logic        uart_we;
  logic [3:0]  uart_addr;
  logic [31:0] uart_wdata;
  logic [31:0] uart_rdata = 32'h0;
  logic        uart_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  // Event word: {kind[3:0], a[31:0], d[31:0]}
  // kinds: 1 store, 2 dmem read, 3 uart request, 4 load, 5 bus error, 6 misalign
  logic [67:0] exp_q[$];

  memory_stage_controller dut (
    .clock             (clock),
    .reset             (reset),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .alu_memory_write  (alu_memory_write),
    .read_data_2_write (read_data_2_write),
    .stall_pipeline    (stall_pipeline),
    .load_data         (load_data),
    .load_valid        (load_valid),
    .bus_error         (bus_error),
    .misalign_error    (misalign_error),
    .dmem_we           (dmem_we),
    .dmem_re           (dmem_re),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_rdata        (dmem_rdata),
    .uart_req          (uart_req),
    .uart_we           (uart_we),
    .uart_addr         (uart_addr),
    .uart_wdata        (uart_wdata),
    .uart_rdata        (uart_rdata),
    .uart_ready        (uart_ready)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic sb_event(input string name, input logic [67:0] act);
    logic [67:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected event actual=%h expected=none", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, act, e);
    end
  endtask

  // ---------------- monitor ----------------
  logic prev_req = 1'b0;
  always @(negedge clock) begin
    if (dmem_we)             sb_event("store",     {4'd1, dmem_addr, dmem_wdata});
    if (dmem_re)             sb_event("dmem_read", {4'd2, dmem_addr, 32'h0});
    if (uart_req && !prev_req)
                             sb_event("uart_req",  {4'd3, 27'h0, uart_we, uart_addr, uart_wdata});
    if (load_valid)          sb_event("load",      {4'd4, 32'h0, load_data});
    if (bus_error)           sb_event("bus_error", {4'd5, 64'h0});
    if (misalign_error)      sb_event("misalign",  {4'd6, 64'h0});
    prev_req = uart_req;
  end

  // ---------------- driver ----------------
  // Holds the request until the stall drops, models DMEM read latency and
  // raises uart_ready in the ready_delay-th request cycle (0 = never).
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int ready_delay,
                           input logic [31:0] rval, output int stall_cyc, output int req_cyc);
    int   wait_cnt;
    logic prev_re;
    bit   done;
    wait_cnt  = 0;
    prev_re   = 1'b0;
    done      = 1'b0;
    stall_cyc = 0;
    req_cyc   = 0;
    @(posedge clock); #1;
    mem_read          = rd;
    mem_write         = wr;
    alu_memory_write  = addr;
    read_data_2_write = wdata;
    uart_rdata        = rval;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clock);
      dmem_rdata = prev_re ? rval : 32'h0;
      prev_re    = dmem_re;
      if (stall_pipeline) stall_cyc++;
      else done = 1'b1;
      if (uart_req) begin
        req_cyc++;
        wait_cnt++;
        uart_ready = (ready_delay != 0) && (wait_cnt == ready_delay);
      end else begin
        uart_ready = 1'b0;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL access_bound actual=stalled expected=release addr=%h", addr);
    end
    @(posedge clock); #1;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    uart_ready = 1'b0;
    dmem_rdata = 32'h0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s, r;
    repeat (2) @(negedge clock);
    check("reset_ctrl", 68'({stall_pipeline, load_valid, bus_error, misalign_error,
                             dmem_we, dmem_re, uart_req, uart_we}), 68'(0));
    check("reset_load_data", 68'(load_data), 68'(0));
    check("reset_uart_regs", 68'({uart_addr, uart_wdata}), 68'(0));
    @(posedge clock); #1;
    reset = 1'b1;

    // DMEM store: same-cycle write enable, no stall
    exp_q.push_back({4'd1, 32'h0000_0040, 32'hDEAD_BEEF});
    do_access(1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 0, 32'h0, s, r);
    check("store_stall", 68'(s), 68'(0));

    // DMEM load: 2 stall cycles then load_valid
    exp_q.push_back({4'd2, 32'h0000_0040, 32'h0});
    exp_q.push_back({4'd4, 32'h0, 32'hDEAD_BEEF});
    do_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 0, 32'hDEAD_BEEF, s, r);
    check("dload_stall", 68'(s), 68'(2));

    // UART write, ready in the third request cycle
    exp_q.push_back({4'd3, 27'h0, 1'b1, 4'h4, 32'h0000_0041});
    do_access(1'b0, 1'b1, 32'h8000_0004, 32'h0000_0041, 3, 32'h0000_0055, s, r);
    check("uwrite_stall", 68'(s), 68'(4));
    check("uwrite_req", 68'(r), 68'(3));

    // UART read timeout after 255 wait cycles
    exp_q.push_back({4'd3, 27'h0, 1'b0, 4'h8, 32'h1234_5678});
    exp_q.push_back({4'd4, 32'h0, 32'h0});
    exp_q.push_back({4'd5, 64'h0});
    do_access(1'b1, 1'b0, 32'h8000_0008, 32'h1234_5678, 0, 32'hA5A5_A5A5, s, r);
    check("timeout_stall", 68'(s), 68'(256));
    check("timeout_req", 68'(r), 68'(255));

    // Misaligned load: pulse only
    exp_q.push_back({4'd6, 64'h0});
    do_access(1'b1, 1'b0, 32'h0000_0042, 32'h0, 0, 32'h1111_1111, s, r);
    check("misalign_stall", 68'(s), 68'(0));

    // Read and write together: write wins
    exp_q.push_back({4'd1, 32'h0000_0080, 32'h0000_0077});
    do_access(1'b1, 1'b1, 32'h0000_0080, 32'h0000_0077, 0, 32'h0, s, r);
    check("priority_stall", 68'(s), 68'(0));

    // UART read, ready in first request cycle
    exp_q.push_back({4'd3, 27'h0, 1'b0, 4'h0, 32'h0});
    exp_q.push_back({4'd4, 32'h0, 32'hCAFE_0042});
    do_access(1'b1, 1'b0, 32'h8000_0000, 32'h0, 1, 32'hCAFE_0042, s, r);
    check("uread_stall", 68'(s), 68'(2));
    check("uread_req", 68'(r), 68'(1));

    // Stray uart_ready in IDLE is ignored
    @(posedge clock); #1;
    uart_ready = 1'b1;
    @(negedge clock);
    check("stray_ready", 68'({stall_pipeline, uart_req}), 68'(0));
    @(posedge clock); #1;
    uart_ready = 1'b0;

    // Reset two cycles into UART_WAIT
    exp_q.push_back({4'd3, 27'h0, 1'b0, 4'hC, 32'h0});
    @(posedge clock); #1;
    mem_read          = 1'b1;
    alu_memory_write  = 32'h8000_000C;
    read_data_2_write = 32'h0;
    repeat (3) @(negedge clock);
    check("pre_reset_req", 68'(uart_req), 68'(1));
    #2 reset = 1'b0;
    #1;
    check("abort_ctrl", 68'({stall_pipeline, uart_req, load_valid, bus_error, dmem_re}), 68'(0));
    check("abort_load_data", 68'(load_data), 68'(0));
    check("abort_uart_addr", 68'(uart_addr), 68'(0));
    mem_read = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
    repeat (3) @(negedge clock);

    // Fresh UART read after the abort
    exp_q.push_back({4'd3, 27'h0, 1'b0, 4'hC, 32'h0});
    exp_q.push_back({4'd4, 32'h0, 32'h0000_0099});
    do_access(1'b1, 1'b0, 32'h8000_000C, 32'h0, 2, 32'h0000_0099, s, r);
    check("fresh_stall", 68'(s), 68'(3));

    repeat (3) @(negedge clock);
    check("queue_empty", 68'(exp_q.size()), 68'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
